// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand register file and the ALU.
package alu_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;

    // Bit positions inside the 4-bit {V,C,N,Z} status word.
    localparam int STAT_V = 3;
    localparam int STAT_C = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef logic [3:0] status_t;

endpackage

// File: rtl/status_flag_reg.sv
// Four-bit load-enabled flag register with synchronous active-low reset.
module status_flag_reg
    import alu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ld_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    status_t status_q;
    status_t status_d;

    // Next state: take the new flags on load, otherwise hold.
    always_comb begin
        status_d = status_q;
        if (ld_i) begin
            status_d = d_i;
        end
    end

    // Flag storage; reset wins over a load in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign q_o = status_q;

endmodule

// File: rtl/alu_operand_regfile.sv
// Two-read / one-write register file feeding the ALU operands, plus the
// latched ALU status flags. Index ZERO_REG always reads as zero.
module alu_operand_regfile
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P = alu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH_P = alu_pkg::ADDR_WIDTH,
    parameter int ZERO_REG_P   = alu_pkg::ZERO_REG,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH_P-1:0] rd_sel_a,
    input  logic [ADDR_WIDTH_P-1:0] rd_sel_b,
    output logic [DATA_WIDTH_P-1:0] a_data,
    output logic [DATA_WIDTH_P-1:0] b_data,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH_P-1:0] wr_sel,
    input  logic [DATA_WIDTH_P-1:0] wr_data,
    input  logic                    status_ld,
    input  logic [3:0]              status_in,
    output logic [3:0]              status_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH_P;
    localparam logic [ADDR_WIDTH_P-1:0] ZERO_IDX = ADDR_WIDTH_P'(ZERO_REG_P);

    logic [DATA_WIDTH_P-1:0] regs_q [NUM_REGS];

    // A write is effective only when enabled, out of reset and not aimed at
    // the zero register. wr_en gates everything so an unknown wr_sel while
    // idle cannot reach the array or the bypass path.
    logic wr_fire;
    assign wr_fire = reset_n && wr_en && (wr_sel != ZERO_IDX);

    // Array update: clear everything on reset, otherwise one write per edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

    // Operand A read: zero register, then same-cycle forwarding, then array.
    always_comb begin
        a_data = regs_q[rd_sel_a];
        if (rd_sel_a == ZERO_IDX) begin
            a_data = '0;
        end else if (BYPASS && wr_fire && (wr_sel == rd_sel_a)) begin
            a_data = wr_data;
        end
    end

    // Operand B read: same priority as operand A, evaluated independently.
    always_comb begin
        b_data = regs_q[rd_sel_b];
        if (rd_sel_b == ZERO_IDX) begin
            b_data = '0;
        end else if (BYPASS && wr_fire && (wr_sel == rd_sel_b)) begin
            b_data = wr_data;
        end
    end

    // Status flags have no forwarding: visible one edge after the load.
    status_flag_reg u_status (
        .clock   (clock),
        .reset_n (reset_n),
        .ld_i    (status_ld),
        .d_i     (status_in),
        .q_o     (status_out)
    );

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Bench for alu_operand_regfile: one instance with forwarding, one without,
// both driven by the same inputs and checked against a behavioural model.
module tb_alu_operand_regfile;

    logic        clock;
    logic        reset_n;
    logic [4:0]  rd_sel_a;
    logic [4:0]  rd_sel_b;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [63:0] wr_data;
    logic        status_ld;
    logic [3:0]  status_in;

    logic [63:0] a_byp, b_byp, a_nob, b_nob;
    logic [3:0]  st_byp, st_nob;

    int checks = 0;
    int errors = 0;

    // Model state: register contents and flags after the last edge.
    logic [63:0] mdl_regs [32];
    logic [3:0]  mdl_status;
    bit          seen_reset = 0;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    alu_operand_regfile #(.BYPASS(1'b1)) dut_byp (
        .clock(clock), .reset_n(reset_n),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .a_data(a_byp), .b_data(b_byp),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .status_ld(status_ld), .status_in(status_in), .status_out(st_byp)
    );

    alu_operand_regfile #(.BYPASS(1'b0)) dut_nob (
        .clock(clock), .reset_n(reset_n),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .a_data(a_nob), .b_data(b_nob),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .status_ld(status_ld), .status_in(status_in), .status_out(st_nob)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read value from the register-file rules.
    function automatic logic [63:0] exp_read(input logic [4:0] sel, input bit fwd);
        if (sel == 5'd31) return 64'd0;
        if (fwd && reset_n && wr_en && (wr_sel == sel)) return wr_data;
        return mdl_regs[sel];
    endfunction

    // ---------------- model update ----------------
    initial begin
        for (int i = 0; i < 32; i++) mdl_regs[i] = 64'd0;
        mdl_status = 4'd0;
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mdl_regs[i] = 64'd0;
            mdl_status = 4'd0;
            seen_reset = 1;
        end else begin
            if (wr_en && (wr_sel != 5'd31)) mdl_regs[wr_sel] = wr_data;
            if (status_ld) mdl_status = status_in;
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clock) begin
        if (seen_reset) begin
            chk("byp_a",  a_byp, exp_read(rd_sel_a, 1'b1));
            chk("byp_b",  b_byp, exp_read(rd_sel_b, 1'b1));
            chk("nob_a",  a_nob, exp_read(rd_sel_a, 1'b0));
            chk("nob_b",  b_nob, exp_read(rd_sel_b, 1'b0));
            chk("byp_st", {60'd0, st_byp}, {60'd0, mdl_status});
            chk("nob_st", {60'd0, st_nob}, {60'd0, mdl_status});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_sel = 5'd0; wr_data = 64'd0;
        status_ld = 1'b0; status_in = 4'd0;
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [63:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Literal check of all four read outputs at the sampling edge.
    task automatic pin_reads(input string name, input logic [63:0] ea_byp,
                             input logic [63:0] eb_byp, input logic [63:0] ea_nob,
                             input logic [63:0] eb_nob);
        @(negedge clock);
        chk({name, "_a_byp"}, a_byp, ea_byp);
        chk({name, "_b_byp"}, b_byp, eb_byp);
        chk({name, "_a_nob"}, a_nob, ea_nob);
        chk({name, "_b_nob"}, b_nob, eb_nob);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; rd_sel_a = 5'd0; rd_sel_b = 5'd0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;

        // Reset then read every index on both ports.
        for (int i = 0; i < 32; i++) begin
            rd_sel_a = 5'(i);
            rd_sel_b = 5'(31 - i);
            pin_reads("reset_read", 64'd0, 64'd0, 64'd0, 64'd0);
            chk("reset_status", {60'd0, st_byp}, 64'd0);
            tick();
        end

        // Write / readback.
        do_write(5'd5, 64'd3);
        do_write(5'd6, 64'd1);
        rd_sel_a = 5'd5; rd_sel_b = 5'd6;
        pin_reads("wr_rb", 64'd3, 64'd1, 64'd3, 64'd1);
        tick();
        do_write(5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_sel_a = 5'd5; rd_sel_b = 5'd5;
        pin_reads("wr_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // Zero register: same-cycle and later reads stay zero.
        rd_sel_a = 5'd31; rd_sel_b = 5'd31;
        wr_en = 1'b1; wr_sel = 5'd31; wr_data = 64'd99;
        pin_reads("zero_same", 64'd0, 64'd0, 64'd0, 64'd0);
        tick();
        wr_en = 1'b0;
        pin_reads("zero_after", 64'd0, 64'd0, 64'd0, 64'd0);
        tick();

        // Forwarding on both ports at once.
        do_write(5'd7, 64'd10);
        rd_sel_a = 5'd7; rd_sel_b = 5'd7;
        wr_en = 1'b1; wr_sel = 5'd7; wr_data = 64'd20;
        pin_reads("bypass_same", 64'd20, 64'd20, 64'd10, 64'd10);
        tick();
        wr_en = 1'b0;
        pin_reads("bypass_next", 64'd20, 64'd20, 64'd20, 64'd20);
        tick();

        // Status load then hold.
        status_in = 4'b0110; status_ld = 1'b1;
        tick();
        status_in = 4'b1001; status_ld = 1'b0;
        @(negedge clock);
        chk("status_load", {60'd0, st_byp}, 64'h6);
        tick();
        @(negedge clock);
        chk("status_hold", {60'd0, st_nob}, 64'h6);
        tick();

        // Reset in the same cycle as a write.
        do_write(5'd3, 64'd7);
        reset_n = 1'b0;
        wr_en = 1'b1; wr_sel = 5'd3; wr_data = 64'd8;
        status_ld = 1'b1; status_in = 4'b1111;
        tick();
        reset_n = 1'b1;
        idle_inputs();
        rd_sel_a = 5'd3; rd_sel_b = 5'd3;
        pin_reads("rst_mid_wr", 64'd0, 64'd0, 64'd0, 64'd0);
        chk("rst_mid_status", {60'd0, st_byp}, 64'd0);
        tick();
        do_write(5'd3, 64'd8);
        pin_reads("post_rst_wr", 64'd8, 64'd8, 64'd8, 64'd8);
        tick();

        // Unknown write index while idle.
        wr_en = 1'b0; wr_sel = 5'bx; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        wr_sel = 5'd0;
        pin_reads("x_idle", 64'd8, 64'd8, 64'd8, 64'd8);
        tick();

        // Randomized traffic checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            wr_en     = $urandom_range(0, 1);
            wr_sel    = 5'($urandom_range(0, 31));
            wr_data   = {$urandom, $urandom};
            rd_sel_a  = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, 31));
            rd_sel_b  = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, 31));
            status_ld = $urandom_range(0, 1);
            status_in = 4'($urandom_range(0, 15));
            tick();
        end

        reset_n = 1'b1;
        idle_inputs();
        tick();
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
